mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between instruction fetch (IF) and load/store (LS).

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 88 ++++++++
 tb/tb_mem_port_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, load/store and memory-side signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic            ls_req;
  logic            ls_we;
  logic [DW/8-1:0] ls_wstrb;
  logic [AW-1:0]   ls_addr;
  logic [DW-1:0]   ls_wdata;
  logic            ls_gnt;
  logic            ls_valid;
  logic [DW-1:0]   ls_rdata;
  logic            mem_en;
  logic            mem_we;
  logic [DW/8-1:0] mem_wstrb;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_wstrb, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
           mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_wstrb, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, ls_gnt, ls_valid, ls_rdata,
           mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store with fixed-latency access.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise LS has priority with an IF starvation guard.
module mem_port_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int MAX_STALL   = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic              busy
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            owner_ls, we, pick_ls, grant_if, grant_ls, last_cyc;
  logic [DW/8-1:0] wstrb;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata, if_rdata, ls_rdata;
`ifdef MEM_ARB_RR_EN
  logic last_if;
  assign pick_ls = bus.ls_req && (!bus.if_req || last_if);
`else
  localparam int SW = MAX_STALL > 0 ? $clog2(MAX_STALL + 1) : 1;
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);
  logic [SW-1:0] stall_cnt;
  assign pick_ls = bus.ls_req && !(bus.if_req && stall_cnt == STALL_MAX);
`endif
  always_comb begin
    grant_ls = state == IDLE && pick_ls;
    grant_if = state == IDLE && bus.if_req && !pick_ls;
    last_cyc = state == ACCESS && cnt == CNT_LAST;
    state_nx = state == IDLE   ? (grant_ls || grant_if ? ACCESS : IDLE)
             : state == ACCESS ? (last_cyc ? DONE : ACCESS)
             : IDLE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      owner_ls <= 1'b0;
      we       <= 1'b0;
      wstrb    <= '0;
      addr     <= '0;
      wdata    <= '0;
      if_rdata <= '0;
      ls_rdata <= '0;
`ifdef MEM_ARB_RR_EN
      last_if  <= 1'b1;
`else
      stall_cnt <= '0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= state != ACCESS || last_cyc ? '0 : cnt + 1'b1;
      if (grant_ls || grant_if) begin
        owner_ls <= grant_ls;
        we       <= grant_ls && bus.ls_we;
        wstrb    <= grant_ls && bus.ls_we ? bus.ls_wstrb : '0;
        addr     <= grant_ls ? bus.ls_addr : bus.if_addr;
        wdata    <= grant_ls ? bus.ls_wdata : '0;
      end
      if (last_cyc && !owner_ls) if_rdata <= bus.mem_rdata;
      if (last_cyc && owner_ls && !we) ls_rdata <= bus.mem_rdata;
`ifdef MEM_ARB_RR_EN
      if (grant_ls || grant_if) last_if <= grant_if;
`else
      if (grant_if) stall_cnt <= '0;
      else if (grant_ls && bus.if_req && stall_cnt != STALL_MAX) stall_cnt <= stall_cnt + 1'b1;
`endif
    end
  end
  assign bus.if_gnt    = grant_if;
  assign bus.ls_gnt    = grant_ls;
  assign bus.if_valid  = state == DONE && !owner_ls;
  assign bus.ls_valid  = state == DONE && owner_ls;
  assign bus.if_rdata  = if_rdata;
  assign bus.ls_rdata  = ls_rdata;
  assign bus.mem_en    = state == ACCESS;
  assign bus.mem_we    = state == ACCESS && we;
  assign bus.mem_wstrb = state == ACCESS ? wstrb : '0;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign busy          = state != IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table, hand sequences and a randomized transaction-level model for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int MS = 4;
  localparam int W1 = 1;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst1_n, rst3_n, busy1, busy3;
  mem_port_arbiter_if #(.AW(32), .DW(32)) a();
  mem_port_arbiter_if #(.AW(32), .DW(32)) b();
  mem_port_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(W1), .MAX_STALL(MS)) dut1 (
    .clk(clk), .reset(rst1_n), .bus(a), .busy(busy1));
  mem_port_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(3), .MAX_STALL(MS)) dut3 (
    .clk(clk), .reset(rst3_n), .bus(b), .busy(busy3));

  function automatic logic [31:0] init_val(input logic [7:0] i);
    return i == 8'd64 ? 32'hDEADBEEF : 32'h1000_0000 | {24'd0, i};
  endfunction

  logic [31:0]  ram [256];
  logic [255:0] wr_mask = '0;
  logic [31:0]  wtmp;
  always_comb a.mem_rdata = !a.mem_en ? 32'h0 : wr_mask[a.mem_addr[9:2]] ? ram[a.mem_addr[9:2]] : init_val(a.mem_addr[9:2]);
  always @(posedge clk) if (a.mem_en && a.mem_we) begin
    wtmp = wr_mask[a.mem_addr[9:2]] ? ram[a.mem_addr[9:2]] : init_val(a.mem_addr[9:2]);
    for (int i = 0; i < 4; i++) if (a.mem_wstrb[i]) wtmp[8*i +: 8] = a.mem_wdata[8*i +: 8];
    ram[a.mem_addr[9:2]] = wtmp;
    wr_mask[a.mem_addr[9:2]] = 1'b1;
  end
  always_comb b.mem_rdata = b.mem_en ? b.mem_addr ^ 32'h5555_5555 : 32'h0;

  int n_run = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic ir, lr, we;
    logic [3:0] strb;
    logic [31:0] addr, wdata;
    logic eig, elg, ewe;
    logic [3:0] estrb;
    logic [31:0] erd;
  } vec_t;
  function automatic vec_t mk(input logic ir, we, input logic [3:0] strb, input logic [31:0] addr, wdata,
                              input logic ewe, input logic [3:0] estrb, input logic [31:0] erd);
    vec_t v;
    v.ir = ir; v.lr = !ir; v.we = we; v.strb = strb; v.addr = addr; v.wdata = wdata;
    v.eig = ir; v.elg = !ir; v.ewe = ewe; v.estrb = estrb; v.erd = erd;
    return v;
  endfunction
  vec_t tbl [8];

  task automatic reset_dut1();
    @(negedge clk) rst1_n = 1'b0;
    @(negedge clk) rst1_n = 1'b1;
  endtask

  function automatic bit rr_or_guard_if(input int k);
`ifdef MEM_ARB_RR_EN
    return k % 2 == 1;
`else
    return k % (MS + 1) == MS;
`endif
  endfunction

  int free_at, g_at, stall;
  bit last_if, ir_p, lr_p, o_ls, o_we, fr, pls, eg_ls, eg_if, acc, vld;
  logic [3:0]  o_strb;
  logic [7:0]  idx;
  logic [31:0] o_addr, o_wdata, o_rd, e_if_rd, e_ls_rd;
  logic [31:0] mdl [256];

  initial begin
    {a.if_req, a.ls_req, a.ls_we, b.if_req, b.ls_req, b.ls_we} = '0;
    {a.if_addr, a.ls_addr, a.ls_wdata, b.if_addr, b.ls_addr, b.ls_wdata} = '0;
    {a.ls_wstrb, b.ls_wstrb} = '0;
    rst1_n = 1'b0; rst3_n = 1'b0;
    tbl[0] = mk(1, 0, 4'h0,    32'h100, 32'h0,        0, 4'h0,    32'hDEADBEEF);
    tbl[1] = mk(0, 0, 4'h0,    32'h200, 32'h0,        0, 4'h0,    32'h1000_0080);
    tbl[2] = mk(0, 1, 4'b0011, 32'h040, 32'h1234,     1, 4'b0011, 32'h1000_0080);
    tbl[3] = mk(0, 0, 4'h0,    32'h040, 32'h0,        0, 4'h0,    32'h1000_1234);
    tbl[4] = mk(1, 0, 4'h0,    32'h040, 32'h0,        0, 4'h0,    32'h1000_1234);
    tbl[5] = mk(0, 1, 4'b1100, 32'h048, 32'hAABBCCDD, 1, 4'b1100, 32'h1000_1234);
    tbl[6] = mk(0, 0, 4'h0,    32'h048, 32'h0,        0, 4'h0,    32'hAABB_0012);
    tbl[7] = mk(1, 0, 4'h0,    32'h104, 32'h0,        0, 4'h0,    32'h1000_0041);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_if_gnt", a.if_gnt, 0);    chk("rst_ls_gnt", a.ls_gnt, 0);
    chk("rst_if_valid", a.if_valid, 0); chk("rst_ls_valid", a.ls_valid, 0);
    chk("rst_if_rdata", a.if_rdata, 0); chk("rst_ls_rdata", a.ls_rdata, 0);
    chk("rst_mem_en", a.mem_en, 0);    chk("rst_mem_we", a.mem_we, 0);
    chk("rst_mem_wstrb", a.mem_wstrb, 0); chk("rst_mem_addr", a.mem_addr, 0);
    chk("rst_mem_wdata", a.mem_wdata, 0); chk("rst_busy", busy1, 0);
    @(negedge clk) begin rst1_n = 1'b1; rst3_n = 1'b1; end
    // single-requester transfers: gnt, one access cycle, then valid
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a.if_req = tbl[k].ir; a.if_addr = tbl[k].addr;
      a.ls_req = tbl[k].lr; a.ls_addr = tbl[k].addr; a.ls_we = tbl[k].we;
      a.ls_wstrb = tbl[k].strb; a.ls_wdata = tbl[k].wdata;
      #1;
      chk("tbl_if_gnt", a.if_gnt, tbl[k].eig); chk("tbl_ls_gnt", a.ls_gnt, tbl[k].elg); chk("tbl_busy_idle", busy1, 0);
      @(negedge clk);
      a.if_req = 0; a.ls_req = 0; a.if_addr = '1; a.ls_addr = '1; a.ls_wdata = '1; a.ls_wstrb = '1; a.ls_we = 1;
      #1;
      chk("tbl_mem_en", a.mem_en, 1); chk("tbl_mem_addr", a.mem_addr, tbl[k].addr);
      chk("tbl_mem_we", a.mem_we, tbl[k].ewe); chk("tbl_mem_wstrb", a.mem_wstrb, tbl[k].estrb);
      if (tbl[k].ewe) chk("tbl_mem_wdata", a.mem_wdata, tbl[k].wdata);
      chk("tbl_busy_acc", busy1, 1);
      @(negedge clk);
      #1;
      chk("tbl_if_valid", a.if_valid, tbl[k].ir); chk("tbl_ls_valid", a.ls_valid, tbl[k].lr);
      chk("tbl_mem_en_done", a.mem_en, 0);
      chk("tbl_rdata", tbl[k].ir ? a.if_rdata : a.ls_rdata, tbl[k].erd);
    end
    a.ls_we = 0; a.ls_wstrb = 0;
    // simultaneous requests: LS first, IF served right after
    reset_dut1();
    @(negedge clk);
    a.if_req = 1; a.if_addr = 32'h100; a.ls_req = 1; a.ls_we = 0; a.ls_wstrb = 0; a.ls_addr = 32'h200;
    #1 chk("tie_ls_gnt", a.ls_gnt, 1); chk("tie_if_gnt_c0", a.if_gnt, 0);
    @(negedge clk) a.ls_req = 0;
    #1 chk("tie_mem_addr_ls", a.mem_addr, 32'h200); chk("tie_if_gnt_c1", a.if_gnt, 0);
    @(negedge clk);
    #1 chk("tie_ls_valid", a.ls_valid, 1); chk("tie_ls_rdata", a.ls_rdata, 32'h1000_0080); chk("tie_if_gnt_c2", a.if_gnt, 0);
    @(negedge clk);
    #1 chk("tie_if_gnt_c3", a.if_gnt, 1);
    @(negedge clk) a.if_req = 0;
    #1 chk("tie_mem_addr_if", a.mem_addr, 32'h100); chk("tie_mem_en_if", a.mem_en, 1);
    @(negedge clk);
    #1 chk("tie_if_valid", a.if_valid, 1); chk("tie_if_rdata", a.if_rdata, 32'hDEADBEEF); chk("tie_ls_rdata_keep", a.ls_rdata, 32'h1000_0080);
    // both requesters held: starvation guard (or alternation in round-robin)
    reset_dut1();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) begin
        a.if_req = 1; a.if_addr = 32'h100; a.ls_req = 1; a.ls_we = 0; a.ls_addr = 32'h200;
      end
      #1;
      if (c % 3 == 0) begin
        chk("hold_if_gnt", a.if_gnt, rr_or_guard_if(c / 3));
        chk("hold_ls_gnt", a.ls_gnt, !rr_or_guard_if(c / 3));
        chk("hold_busy_idle", busy1, 0);
      end else begin
        chk("hold_no_gnt", {a.if_gnt, a.ls_gnt}, 0);
        chk("hold_busy", busy1, 1);
      end
      if (c % 3 == 2) chk("hold_if_valid", a.if_valid, rr_or_guard_if(c / 3));
    end
    @(negedge clk) begin a.if_req = 0; a.ls_req = 0; end
    repeat (3) @(negedge clk);
    // reset in the middle of a 3-cycle access
    @(negedge clk) begin b.if_req = 1; b.if_addr = 32'h300; end
    #1 chk("ar_if_gnt", b.if_gnt, 1);
    @(negedge clk) b.if_req = 0;
    #1 chk("ar_mem_en_c1", b.mem_en, 1); chk("ar_mem_addr", b.mem_addr, 32'h300);
    @(negedge clk);
    #1 chk("ar_mem_en_c2", b.mem_en, 1);
    #2 rst3_n = 1'b0;
    #1 chk("ar_mem_en_drop", b.mem_en, 0); chk("ar_busy_drop", busy3, 0);
    repeat (4) begin
      @(negedge clk);
      #1 chk("ar_no_valid", b.if_valid, 0); chk("ar_no_mem_en", b.mem_en, 0);
    end
    @(negedge clk) rst3_n = 1'b1;
    @(negedge clk) begin b.if_req = 1; b.if_addr = 32'h304; end
    #1 chk("ar2_if_gnt", b.if_gnt, 1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk) b.if_req = 0;
      #1 chk("ar2_mem_en", b.mem_en, 1); chk("ar2_if_valid_early", b.if_valid, 0);
    end
    @(negedge clk);
    #1 chk("ar2_mem_en_off", b.mem_en, 0); chk("ar2_if_valid", b.if_valid, 1);
    chk("ar2_if_rdata", b.if_rdata, 32'h304 ^ 32'h5555_5555);
    // randomized traffic against a cycle-numbered transaction model
    reset_dut1();
    for (int i = 0; i < 256; i++) mdl[i] = wr_mask[i] ? ram[i] : init_val(8'(i));
    free_at = 0; g_at = -10; stall = 0; last_if = 1; ir_p = 0; lr_p = 0; o_ls = 0; o_we = 0;
    o_strb = 0; o_addr = 0; o_wdata = 0; o_rd = 0; e_if_rd = 0; e_ls_rd = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (!ir_p && $urandom_range(0, 3) == 0) begin
        ir_p = 1; a.if_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!lr_p && $urandom_range(0, 3) != 0) begin
        lr_p = 1; a.ls_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        a.ls_we = 1'($urandom_range(0, 1)); a.ls_wstrb = 4'($urandom_range(1, 15)); a.ls_wdata = $urandom;
      end
      a.if_req = ir_p; a.ls_req = lr_p;
      #1;
      fr = cyc >= free_at;
`ifdef MEM_ARB_RR_EN
      pls = lr_p && (!ir_p || last_if);
`else
      pls = lr_p && !(ir_p && stall == MS);
`endif
      eg_ls = fr && pls;
      eg_if = fr && ir_p && !pls;
      acc = cyc > g_at && cyc <= g_at + W1;
      vld = cyc == g_at + W1 + 1;
      if (vld && !o_ls) e_if_rd = o_rd;
      if (vld && o_ls && !o_we) e_ls_rd = o_rd;
      chk("rnd_if_gnt", a.if_gnt, eg_if); chk("rnd_ls_gnt", a.ls_gnt, eg_ls);
      chk("rnd_busy", busy1, acc || vld); chk("rnd_mem_en", a.mem_en, acc);
      chk("rnd_if_valid", a.if_valid, vld && !o_ls); chk("rnd_ls_valid", a.ls_valid, vld && o_ls);
      chk("rnd_if_rdata", a.if_rdata, e_if_rd); chk("rnd_ls_rdata", a.ls_rdata, e_ls_rd);
      if (acc) begin
        chk("rnd_mem_addr", a.mem_addr, o_addr); chk("rnd_mem_we", a.mem_we, o_we);
        if (!o_ls || o_we) chk("rnd_mem_wstrb", a.mem_wstrb, o_strb);
        if (o_we) chk("rnd_mem_wdata", a.mem_wdata, o_wdata);
      end
      if (eg_ls || eg_if) begin
        g_at = cyc; free_at = cyc + W1 + 2; o_ls = eg_ls;
        o_addr = eg_ls ? a.ls_addr : a.if_addr;
        o_we = eg_ls && a.ls_we;
        o_strb = o_we ? a.ls_wstrb : 4'h0;
        o_wdata = a.ls_wdata;
        idx = o_addr[9:2];
        o_rd = mdl[idx];
        for (int j = 0; j < 4; j++) if (o_strb[j]) mdl[idx][8*j +: 8] = o_wdata[8*j +: 8];
        if (eg_if) stall = 0;
        else if (ir_p) stall = stall < MS ? stall + 1 : MS;
        last_if = eg_if;
        if (eg_if) ir_p = 0;
        if (eg_ls) lr_p = 0;
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
